// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// The GAP/ON encoding is fixed so checkers can bind to it directly.
package seg_pkg;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam int         DIGIT_W   = 4;

  typedef enum logic {
    GAP = 1'b0,
    ON  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Signal bundle between the scan controller and whatever drives and observes it.
// LOAD is a single-cycle strobe with no back-pressure: it is accepted on every clock it is high.
interface seg_scan_ctrl_if #(
  parameter int N_DIGITS = 4
) ();
  import seg_pkg::*;

  logic                        LOAD;
  logic [DIGIT_W*N_DIGITS-1:0] VALUE;
  logic                        LZ_BLANK;
  logic [DIGIT_W-1:0]          BCD_OUT;
  logic [N_DIGITS-1:0]         DIGIT_EN;
  logic                        FRAME_DONE;
  logic                        PENDING;
  scan_state_t                 STATE_DBG;

  modport master (
    output LOAD, VALUE, LZ_BLANK,
    input  BCD_OUT, DIGIT_EN, FRAME_DONE, PENDING, STATE_DBG
  );

  modport slave (
    input  LOAD, VALUE, LZ_BLANK,
    output BCD_OUT, DIGIT_EN, FRAME_DONE, PENDING, STATE_DBG
  );

endinterface

// File: rtl/seg_scan_timer.sv
// Slot counter, digit index and GAP/ON state for the scan controller.
// FRAME_DONE marks the last cycle of the last digit's slot.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = $clog2(REFRESH_DIV),
  parameter int IDX_W        = $clog2(N_DIGITS)
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [CNT_W-1:0] o_cnt,
  output logic [IDX_W-1:0] o_idx,
  output scan_state_t      o_state,
  output logic             o_frame_done
);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  scan_state_t      r_state;
  scan_state_t      w_state_next;
  logic             w_cnt_wrap;
  logic             w_idx_last;

  assign w_cnt_wrap = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_idx_last = (r_idx == IDX_W'(N_DIGITS - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= GAP;
    end else begin
      r_state <= w_state_next;
      if (w_cnt_wrap) begin
        r_cnt <= '0;
        r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // The state leads the counter by one edge so it flips together with it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      GAP:     if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) w_state_next = ON;
      ON:      if (w_cnt_wrap) w_state_next = GAP;
      default: w_state_next = GAP;
    endcase
  end

  assign o_cnt        = r_cnt;
  assign o_idx        = r_idx;
  assign o_state      = r_state;
  assign o_frame_done = w_cnt_wrap && w_idx_last;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-cathode 7-segment scan controller with a double-buffered
// display value (swapped only at frame boundaries) and optional leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic            CLK,
  input  logic            RST,
  seg_scan_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int VAL_W = DIGIT_W * N_DIGITS;

  logic [VAL_W-1:0]    r_active;
  logic [VAL_W-1:0]    r_shadow;
  logic                r_pending;

  logic [CNT_W-1:0]    w_cnt;
  logic [IDX_W-1:0]    w_idx;
  scan_state_t         w_state;
  logic                w_frame_done;
  logic [N_DIGITS-1:0] w_blank_mask;
  logic                w_upper_zero;
  logic [DIGIT_W-1:0]  w_digit;

  seg_scan_timer #(
    .N_DIGITS     (N_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W),
    .IDX_W        (IDX_W)
  ) u_timer (
    .CLK          (CLK),
    .RST          (RST),
    .o_cnt        (w_cnt),
    .o_idx        (w_idx),
    .o_state      (w_state),
    .o_frame_done (w_frame_done)
  );

  // A LOAD on the boundary cycle wins over the swap, deferring it a full frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else if (bus.LOAD) begin
      r_shadow  <= bus.VALUE;
      r_pending <= 1'b1;
    end else if (w_frame_done && r_pending) begin
      r_active  <= r_shadow;
      r_pending <= 1'b0;
    end
  end

  // Walk from the most significant digit down, tracking "everything above is zero".
  always_comb begin
    w_upper_zero = 1'b1;
    w_blank_mask = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_upper_zero = w_upper_zero && (r_active[k*DIGIT_W +: DIGIT_W] == '0);
      if (k != 0) w_blank_mask[k] = bus.LZ_BLANK && w_upper_zero;
    end
  end

  assign w_digit = r_active[DIGIT_W*int'(w_idx) +: DIGIT_W];

  assign bus.BCD_OUT    = w_digit;
  assign bus.DIGIT_EN   = (w_state == ON && !w_blank_mask[w_idx])
                          ? (N_DIGITS'(1) << w_idx) : '0;
  assign bus.FRAME_DONE = w_frame_done;
  assign bus.PENDING    = r_pending;
  assign bus.STATE_DBG  = w_state;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios with literal expectations plus
// randomized loads/blanking checked every cycle against a frame-level model.
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int W   = 4 * N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.N_DIGITS(N)) bus ();

  seg_scan_ctrl #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: position in time is t mod frame, digit = slot of the frame.
  int         m_t;
  logic [W-1:0] m_active, m_shadow;
  logic       m_pend;
  int         e_slot, e_pos;
  logic       e_blank, e_fd;
  logic [3:0] e_en, e_bcd;

  always @(negedge clk) begin
    if (rst) begin
      m_t = 0; m_active = '0; m_shadow = '0; m_pend = 1'b0;
      check("rst_en",   32'(bus.DIGIT_EN),   32'h0);
      check("rst_bcd",  32'(bus.BCD_OUT),    32'h0);
      check("rst_fd",   32'(bus.FRAME_DONE), 32'h0);
      check("rst_pend", 32'(bus.PENDING),    32'h0);
    end else begin
      e_slot  = (m_t / DIV) % N;
      e_pos   = m_t % DIV;
      e_bcd   = 4'((m_active >> (4 * e_slot)) & 16'hF);
      e_blank = bus.LZ_BLANK && (e_slot > 0) && ((m_active >> (4 * e_slot)) == '0);
      e_en    = (e_pos >= BLK && !e_blank) ? (4'b0001 << e_slot) : 4'b0000;
      e_fd    = (e_slot == N - 1) && (e_pos == DIV - 1);
      check("cmp_en",    32'(bus.DIGIT_EN),   32'(e_en));
      check("cmp_bcd",   32'(bus.BCD_OUT),    32'(e_bcd));
      check("cmp_fd",    32'(bus.FRAME_DONE), 32'(e_fd));
      check("cmp_pend",  32'(bus.PENDING),    32'(m_pend));
      check("cmp_state", 32'(bus.STATE_DBG),  (e_pos >= BLK) ? 32'(ON) : 32'(GAP));
      if (bus.LOAD) begin
        m_shadow = bus.VALUE;
        m_pend   = 1'b1;
      end else if (e_fd && m_pend) begin
        m_active = m_shadow;
        m_pend   = 1'b0;
      end
      m_t++;
    end
  end

  // ---------------- driver tasks ----------------
  int cur;

  task automatic tick();
    @(posedge clk); #1;
    cur++;
  endtask

  task automatic go_to(input int c);
    while (cur < c) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.LOAD = 1'b0; bus.VALUE = '0; bus.LZ_BLANK = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cur = 0;
  endtask

  task automatic load_at(input int c, input logic [W-1:0] v);
    go_to(c);
    bus.LOAD = 1'b1; bus.VALUE = v;
    tick();
    bus.LOAD = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_value();
    logic [W-1:0] v;
    for (int d = 0; d < N; d++)
      v[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    cur = 0;
    do_reset();

    // Idle scan after reset
    check("idle_c0_en", 32'(bus.DIGIT_EN), 32'h0);
    go_to(3);  check("idle_c3_en",  32'(bus.DIGIT_EN), 32'b0001);
    go_to(13); check("idle_c13_en", 32'(bus.DIGIT_EN), 32'b0010);
    go_to(30); check("idle_c30_fd", 32'(bus.FRAME_DONE), 32'h0);
    go_to(31); check("idle_c31_fd", 32'(bus.FRAME_DONE), 32'h1);
    go_to(33); check("idle_c33_en", 32'(bus.DIGIT_EN), 32'h0);
    go_to(63); check("idle_c63_fd", 32'(bus.FRAME_DONE), 32'h1);

    // Single load displayed after first boundary
    do_reset();
    load_at(5, 16'h1234);
    check("ld_c6_pend", 32'(bus.PENDING), 32'h1);
    go_to(31); check("ld_c31_pend", 32'(bus.PENDING), 32'h1);
    go_to(32); check("ld_c32_pend", 32'(bus.PENDING), 32'h0);
    check("ld_c32_bcd", 32'(bus.BCD_OUT), 32'h4);
    exp_q.push_back(4'h4); exp_q.push_back(4'h3);
    exp_q.push_back(4'h2); exp_q.push_back(4'h1);
    for (int s = 0; s < N; s++) begin
      go_to(34 + 8 * s);
      check("ld_seq_en",  32'(bus.DIGIT_EN), 32'(4'b0001 << s));
      check("ld_seq_bcd", 32'(bus.BCD_OUT),  32'(exp_q.pop_front()));
    end

    // Last load before the boundary wins
    do_reset();
    load_at(3, 16'h1111);
    load_at(20, 16'h5678);
    go_to(32); check("lw_c32_bcd", 32'(bus.BCD_OUT), 32'h8);
    go_to(42); check("lw_c42_bcd", 32'(bus.BCD_OUT), 32'h7);

    // Load on the boundary cycle defers by one frame
    go_to(63); check("bd_c63_fd", 32'(bus.FRAME_DONE), 32'h1);
    bus.LOAD = 1'b1; bus.VALUE = 16'h9999;
    tick();
    bus.LOAD = 1'b0;
    check("bd_c64_bcd",  32'(bus.BCD_OUT), 32'h8);
    check("bd_c64_pend", 32'(bus.PENDING), 32'h1);
    go_to(96); check("bd_c96_bcd",  32'(bus.BCD_OUT), 32'h9);
    check("bd_c96_pend", 32'(bus.PENDING), 32'h0);

    // Leading-zero blanking
    do_reset();
    bus.LZ_BLANK = 1'b1;
    load_at(0, 16'h0050);
    go_to(34); check("lz_d0_en", 32'(bus.DIGIT_EN), 32'b0001);
    go_to(42); check("lz_d1_en", 32'(bus.DIGIT_EN), 32'b0010);
    check("lz_d1_bcd", 32'(bus.BCD_OUT), 32'h5);
    go_to(50); check("lz_d2_en", 32'(bus.DIGIT_EN), 32'h0);
    go_to(58); check("lz_d3_en", 32'(bus.DIGIT_EN), 32'h0);
    load_at(64, 16'h0000);
    go_to(98);  check("lz0_d0_en", 32'(bus.DIGIT_EN), 32'b0001);
    go_to(106); check("lz0_d1_en", 32'(bus.DIGIT_EN), 32'h0);
    go_to(122); check("lz0_d3_en", 32'(bus.DIGIT_EN), 32'h0);
    go_to(128); bus.LZ_BLANK = 1'b0;
    go_to(138); check("nolz_d1_en", 32'(bus.DIGIT_EN), 32'b0010);

    // Asynchronous reset mid-slot with a pending value
    do_reset();
    load_at(2, 16'h4321);
    go_to(35); check("ar_c35_en",  32'(bus.DIGIT_EN), 32'b0001);
    check("ar_c35_bcd", 32'(bus.BCD_OUT), 32'h1);
    load_at(36, 16'h8888);
    check("ar_c37_pend", 32'(bus.PENDING), 32'h1);
    go_to(38);
    #2 rst = 1'b1;
    #1;
    check("ar_now_en",   32'(bus.DIGIT_EN),   32'h0);
    check("ar_now_bcd",  32'(bus.BCD_OUT),    32'h0);
    check("ar_now_pend", 32'(bus.PENDING),    32'h0);
    check("ar_now_st",   32'(bus.STATE_DBG),  32'(GAP));
    @(posedge clk); #1 rst = 1'b0;
    cur = 0;
    check("ar_rel_pend", 32'(bus.PENDING), 32'h0);
    go_to(2);  check("ar_c2_en",  32'(bus.DIGIT_EN), 32'b0001);
    check("ar_c2_bcd", 32'(bus.BCD_OUT), 32'h0);
    go_to(34); check("ar_c34_bcd", 32'(bus.BCD_OUT), 32'h0);

    // Randomized loads and blanking, checked by the per-cycle model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if ((c % DIV) == 0 && $urandom_range(0, 3) == 0)
        bus.LZ_BLANK = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        bus.LOAD  = 1'b1;
        bus.VALUE = rand_value();
      end
      tick();
      bus.LOAD = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
